// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, widths and request decode for the data-memory responder
package dmem_pkg;
  localparam int DMEM_DW = 32;
  localparam int DMEM_NB = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} dmem_state_t;
  typedef struct packed {
    logic        err;
    logic [29:0] idx;
  } dmem_chk_t;
  function automatic dmem_chk_t dmem_check(input logic [31:0] addr, input logic we, input logic [3:0] be, input int dlog2);
    dmem_chk_t r;
    r.idx = addr[31:2];
    r.err = (addr >> (dlog2 + 2)) != 32'd0 || (addr[1:0] != 2'd0 && (!we || be != 4'd0));
    return r;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return &x ? x : x + 32'd1;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage with byte-lane writes and registered read, zeroed at time 0
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DMEM_NB-1:0]    be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DMEM_DW-1:0]    wdata,
  output logic [DMEM_DW-1:0]    rdata
);
  logic [DMEM_DW-1:0] mem [2**DEPTH_LOG2] = '{default: '0};
  logic [DMEM_DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < DMEM_NB; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata_q <= mem[idx];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder with valid/ready request and response ports
// Optional DMEM_STATS_EN adds saturating load/store/error access counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [DMEM_DW-1:0] req_wdata,
  input  logic [DMEM_NB-1:0] req_be,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DMEM_DW-1:0] resp_rdata,
  output logic               resp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]        stat_loads,
  output logic [31:0]        stat_stores,
  output logic [31:0]        stat_errors
`endif
);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  dmem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d, rd_ok_q, rd_ok_d;
  logic we_q, we_d, err_q, err_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DMEM_DW-1:0] wdata_q, wdata_d, arr_rdata;
  logic [DMEM_NB-1:0] be_q, be_d;
  logic cap, acc, idx_unused;
  dmem_chk_t chk;
  assign chk = dmem_check(req_addr, req_we, req_be, DEPTH_LOG2);
  assign idx_unused = ^chk.idx[29:DEPTH_LOG2];
  assign cap = state_q == IDLE && req_valid;
  assign acc = state_q == WAIT && cnt_q == 4'd0;
  always_comb begin
    state_d = state_q == IDLE ? (req_valid ? WAIT : IDLE)
            : state_q == WAIT ? (cnt_q == 4'd0 ? RESP : WAIT)
            : (resp_ready ? IDLE : RESP);
    cnt_d = cap ? CNT_INIT : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    req_ready_d = state_d == IDLE;
    resp_valid_d = state_d == RESP;
    resp_err_d = acc ? err_q : resp_err_q;
    rd_ok_d = acc ? !we_q && !err_q : rd_ok_q;
    we_d = cap ? req_we : we_q;
    err_d = cap ? chk.err : err_q;
    idx_d = cap ? chk.idx[DEPTH_LOG2-1:0] : idx_q;
    wdata_d = cap ? req_wdata : wdata_q;
    be_d = cap ? req_be : be_q;
  end
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d, stat_stores_q, stat_stores_d, stat_errors_q, stat_errors_d;
  always_comb begin
    stat_loads_d = acc && !err_q && !we_q ? sat_inc(stat_loads_q) : stat_loads_q;
    stat_stores_d = acc && !err_q && we_q ? sat_inc(stat_stores_q) : stat_stores_q;
    stat_errors_d = acc && err_q ? sat_inc(stat_errors_q) : stat_errors_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads_q <= '0;
      stat_stores_q <= '0;
      stat_errors_q <= '0;
    end else begin
      stat_loads_q <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errors_q <= stat_errors_d;
    end
  end
  assign stat_loads = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errors = stat_errors_q;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      req_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_ready_q <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q <= resp_err_d;
      rd_ok_q <= rd_ok_d;
    end
    we_q <= we_d;
    err_q <= err_d;
    idx_q <= idx_d;
    wdata_q <= wdata_d;
    be_q <= be_d;
  end
  // a reset landing on the access edge must not commit the store
  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (acc && we_q && !err_q && !reset),
    .re    (acc),
    .be    (be_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );
  assign req_ready = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err = resp_err_q;
  assign resp_rdata = rd_ok_q ? arr_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (DEPTH_LOG2=8, LATENCY=2)
module tb_dmem_responder;
  localparam int L = 2;
  typedef struct packed {logic err; logic [31:0] rdata;} exp_t;
  logic clk = 0, reset = 1, req_valid = 0, req_we = 0, rdy_main = 1, bp_en = 0, bp_rdy = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, resp_valid, resp_err, resp_ready, prev_v = 0;
  logic [31:0] resp_rdata, a, d, old;
  logic [3:0] b;
  logic w;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] mdl [256];
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errors;
`endif
  assign resp_ready = bp_en ? bp_rdy : rdy_main;
  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef DMEM_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bp_en) bp_rdy <= 1'($urandom_range(0, 1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) prev_v <= 0;
    else begin
      if (resp_valid && !prev_v) check("latency", 32'(cyc - acc_cyc), L);
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) check("unexpected_resp", 1, 0);
        else begin
          e = q.pop_front();
          check("rdata", resp_rdata, e.rdata);
          check("err", {31'd0, resp_err}, {31'd0, e.err});
        end
      end
      prev_v <= resp_valid;
    end
  end
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    exp_t x;
    int n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    x.err = (addr >> 10) != 0 || (addr[1:0] != 0 && (!we || be != 0));
    x.rdata = (x.err || we) ? 32'd0 : mdl[addr[9:2]];
    if (!x.err && we) for (int i = 0; i < 4; i++) if (be[i]) mdl[addr[9:2]][8*i +: 8] = wdata[8*i +: 8];
    q.push_back(x);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    q.delete();
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 0);
    check({tag, "_rdata"}, resp_rdata, 0);
    check({tag, "_err"}, {31'd0, resp_err}, 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 0;
    send(1, 32'h10, 32'hDEADBEEF, 4'hF);
    send(0, 32'h10, 0, 0);
    send(1, 32'h20, 32'h0, 4'hF);
    send(1, 32'h20, 32'hAABBCCDD, 4'h5);
    send(0, 32'h20, 0, 0);
    send(1, 32'h0, 32'h11223344, 4'hF);
    send(0, 32'h400, 0, 0);
    send(0, 32'h0, 0, 0);
    send(0, 32'h13, 0, 0);
    send(1, 32'h14, 32'hFFFFFFFF, 4'h0);
    send(0, 32'h14, 0, 0);
    send(1, 32'h11, 32'h55555555, 4'hF);
    send(0, 32'h10, 0, 0);
    drain();
    rdy_main = 0;
    send(0, 32'h10, 0, 0);
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
    check("stall_valid_seen", {31'd0, resp_valid}, 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", {31'd0, resp_valid}, 1);
      check("stall_rdata", resp_rdata, 32'hDEADBEEF);
      check("stall_err", {31'd0, resp_err}, 0);
      check("stall_req_ready", {31'd0, req_ready}, 0);
    end
    @(posedge clk);
    #1 rdy_main = 1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_req_ready", {31'd0, req_ready}, 1);
    check("post_hs_valid", {31'd0, resp_valid}, 0);
    send(0, 32'h20, 0, 0);
    drain();
    old = mdl[12];
    send(1, 32'h30, 32'h12345678, 4'hF);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    q.delete();
    mdl[12] = old;
    check_idle("midreset");
    send(0, 32'h30, 0, 0);
    drain();
    bp_en = 1;
    repeat (40) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2047)) : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a[31] = 1;
      w = 1'($urandom); d = $urandom; b = 4'($urandom);
      send(w, a, d, b);
    end
    drain();
    bp_en = 0;
    drain();
`ifdef DMEM_STATS_EN
    do_reset();
    check("stat_loads_clr", stat_loads, 0);
    send(0, 32'h0, 0, 0);
    send(0, 32'h4, 0, 0);
    send(0, 32'h8, 0, 0);
    send(1, 32'h40, 32'hCAFEF00D, 4'hF);
    send(1, 32'h44, 32'h0BADC0DE, 4'h3);
    send(0, 32'h1, 0, 0);
    drain();
    check("stat_loads", stat_loads, 3);
    check("stat_stores", stat_stores, 2);
    check("stat_errors", stat_errors, 1);
    do_reset();
    check("stat_loads_rst", stat_loads, 0);
    check("stat_stores_rst", stat_stores, 0);
    check("stat_errors_rst", stat_errors, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake, services it after a fixed programmable latency, and returns a response over a second valid/ready handshake.
- Replaces the single-cycle combinational data-memory array so that multi-cycle memory timing can be modelled. The core-side initiator is a separate block.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words (256 words).
- LATENCY, 2, cycles from request accept to response valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index is bits [DEPTH_LOG2+1:2].
- req_wdata  in  32  store data.
- req_be  in  4  byte-lane write enables; ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was out of range or misaligned.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset values:
  - State = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - Storage is not cleared by reset; it is zero-initialised at time 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, the request is accepted at that edge: capture we, addr, wdata, be; load counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready = 0.
  - Each edge: if counter == 0, perform the access and go to RESP; otherwise decrement.
  - resp_valid therefore rises exactly LATENCY cycles after the accept edge.
- Access rules:
  - Error if req_addr[31:DEPTH_LOG2+2] != 0, or if addr[1:0] != 0 on a load, or on a store with any be bit set.
  - Error → no write, resp_rdata = 0, resp_err = 1.
  - Store → write only the lanes with be bit set; be = 0000 is a legal no-op.
  - Load → resp_rdata = full word.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready, go to IDLE and drop resp_valid the next cycle.
- Only one request is outstanding at a time. The earliest next accept is the cycle after the response handshake, so maximum throughput is one request per LATENCY+2 cycles.
- Changes to req_* inputs while in WAIT or RESP are ignored.
- Reset mid-operation: return to IDLE, drop any pending response, and discard an uncommitted store. A store already committed stays written.

Optional Feature:
- DMEM_STATS_EN defined:
  - Adds output ports stat_loads[31:0], stat_stores[31:0], stat_errors[31:0].
  - Each counter increments at the cycle an access is performed, classified by type or error. Errors count only in stat_errors.
  - Counters are cleared by reset, saturate at all-ones, and do not wrap.
- DMEM_STATS_EN undefined: these ports and counters do not exist.

Decomposition:
- Package dmem_pkg:
  - State encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2).
  - Data width 32 and byte-lane count 4.
  - The function computing word index and error flag from addr/we/be.
- Sub-module dmem_array:
  - Single-port 32-bit storage with per-byte write enable and registered read.
  - Instantiated once; holds the zero-initialisation.

Test Plan:
- LATENCY = 2, store addr 0x10, wdata 0xDEADBEEF, be = 1111; then load addr 0x10 with resp_ready held 1 → store resp after 2 cycles with err = 0; load resp_rdata = 0xDEADBEEF exactly 2 cycles after accept.
- Store 0x00000000 to 0x20, then store 0xAABBCCDD with be = 0101, then load 0x20 → 0x00BB00DD.
- Load addr 0x400 (out of range for DEPTH_LOG2 = 8) → resp_err = 1, resp_rdata = 0; a following load from 0x0 returns the prior contents unchanged.
- Load addr 0x13 → resp_err = 1. Store addr 0x14, be = 0000 → err = 0, memory at 0x14 unchanged.
- Hold resp_ready = 0 for 5 cycles during a load response → resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0; resp_ready = 1 → IDLE next cycle and the next request is accepted.
- Assert reset during WAIT of a store to 0x30 with wdata 0x12345678 → after reset, load 0x30 returns 0. With DMEM_STATS_EN: 3 loads, 2 stores and 1 error give counters 3/2/1, and all are 0 after reset.
